// File: rtl/gpio_pkg.sv
// Shared constants and read-address decode for the 28-pin GPIO reader.
// Address map: pins 0..27, then level, rise, fall and reserved words.
package gpio_pkg;

  localparam int NUM_PINS = 28;

  localparam logic [4:0] ADR_LEVEL = 5'd28;
  localparam logic [4:0] ADR_RISE  = 5'd29;
  localparam logic [4:0] ADR_FALL  = 5'd30;
  localparam logic [4:0] ADR_RSVD  = 5'd31;

  typedef logic [NUM_PINS-1:0] pins_t;

  typedef enum logic [2:0] {
    SEL_PIN,
    SEL_LEVEL,
    SEL_RISE,
    SEL_FALL,
    SEL_RSVD
  } sel_e;

  function automatic sel_e decode(
    input logic [4:0] adr
  );
    sel_e sel;
    sel = SEL_RSVD;
    if (adr < ADR_LEVEL)
      sel = SEL_PIN;
    else if (adr == ADR_LEVEL)
      sel = SEL_LEVEL;
    else if (adr == ADR_RISE)
      sel = SEL_RISE;
    else if (adr == ADR_FALL)
      sel = SEL_FALL;
    return sel;
  endfunction

  function automatic logic [31:0] widen(
    input pins_t v
  );
    return {{(32-NUM_PINS){1'b0}}, v};
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One pin: two-flop synchronizer, debounce counter and edge pulses.
// rise/fall pulse in the cycle before level takes the new value.
module gpio_debounce #(
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] LAST = 8'(DEBOUNCE_CNT - 1);

  logic       meta;
  logic       sync;
  logic [7:0] cnt;
  logic       differ;
  logic       accept;

  assign differ = sync ^ level;
  assign accept = differ && (cnt == LAST);
  assign rise   = accept & sync;
  assign fall   = accept & ~sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= pin;
      sync <= meta;
    end
  end

  // any cycle of agreement restarts the count
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      if (!differ || accept)
        cnt <= '0;
      else
        cnt <= cnt + 8'd1;
      if (accept)
        level <= sync;
    end
  end

endmodule

// File: rtl/gpio_reader_28pins.sv
// 28-pin debounced GPIO reader with sticky edge status and a
// registered, one-cycle-valid read port.
module gpio_reader_28pins
  import gpio_pkg::*;
#(
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4:0]          IOAdr,
  input  logic                ReadIO,
  input  logic [NUM_PINS-1:0] gpio_in,
  output logic [31:0]         IORead,
  output logic                IOValid,
  output logic                irq
);

  pins_t       stable;
  pins_t       rise_ev;
  pins_t       fall_ev;
  pins_t       rise_sts;
  pins_t       fall_sts;
  pins_t       rise_clr;
  pins_t       fall_clr;
  logic [31:0] read_word;
  sel_e        sel;

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_CNT(DEBOUNCE_CNT)
    ) u_deb (
      .clk  (clk),
      .reset(reset),
      .pin  (gpio_in[i]),
      .level(stable[i]),
      .rise (rise_ev[i]),
      .fall (fall_ev[i])
    );
  end

  assign sel = decode(IOAdr);

  always_comb begin
    read_word = '0;
    rise_clr  = '0;
    fall_clr  = '0;
    unique case (sel)
      SEL_PIN:   read_word = {31'b0, stable[IOAdr]};
      SEL_LEVEL: read_word = widen(stable);
      SEL_RISE: begin
        read_word = widen(rise_sts);
        rise_clr  = ReadIO ? rise_sts : '0;
      end
      SEL_FALL: begin
        read_word = widen(fall_sts);
        fall_clr  = ReadIO ? fall_sts : '0;
      end
      SEL_RSVD:  read_word = '0;
      default:   read_word = '0;
    endcase
  end

  // a fresh edge overrides the read-clear of the same bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rise_sts <= '0;
      fall_sts <= '0;
    end else begin
      rise_sts <= (rise_sts & ~rise_clr) | rise_ev;
      fall_sts <= (fall_sts & ~fall_clr) | fall_ev;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      IORead  <= '0;
      IOValid <= 1'b0;
    end else begin
      IOValid <= ReadIO;
      IORead  <= ReadIO ? read_word : '0;
    end
  end

  assign irq = |{rise_sts, fall_sts};

endmodule

// File: tb/tb_gpio_reader_28pins.sv
// Bench for gpio_reader_28pins: directed scenarios plus random
// pin activity checked against a pin-level behavioural model.
module tb_gpio_reader_28pins;

  localparam int DEB = 8;
  localparam int N   = 28;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  IOAdr;
  logic        ReadIO;
  logic [27:0] gpio_in;
  logic [31:0] IORead;
  logic        IOValid;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gpio_reader_28pins #(
    .DEBOUNCE_CNT(DEB)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .IOAdr  (IOAdr),
    .ReadIO (ReadIO),
    .gpio_in(gpio_in),
    .IORead (IORead),
    .IOValid(IOValid),
    .irq    (irq)
  );

  // model: pin seen two edges late, accepted after DEB differing samples
  logic [27:0] m_s1, m_s2, m_stable, m_rise, m_fall;
  int          m_run[N];
  logic [31:0] m_read;
  logic        m_valid;

  function automatic logic m_irq();
    return |{m_rise, m_fall};
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_stable = '0;
    m_rise = '0; m_fall = '0;
    m_read = '0; m_valid = 1'b0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
  endtask

  task automatic step();
    logic [27:0] in_c, nst, er, ef, cr, cf;
    logic        rd_c;
    logic [4:0]  adr_c;
    in_c = gpio_in; rd_c = ReadIO; adr_c = IOAdr;
    @(posedge clk);
    nst = m_stable; er = '0; ef = '0; cr = '0; cf = '0;
    for (int i = 0; i < N; i++) begin
      if (m_s2[i] != m_stable[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          nst[i] = m_s2[i];
          m_run[i] = 0;
          if (m_s2[i]) er[i] = 1'b1;
          else         ef[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_valid = rd_c;
    m_read  = '0;
    if (rd_c) begin
      if (adr_c < 5'd28)
        m_read = {31'b0, m_stable[adr_c]};
      else if (adr_c == 5'd28)
        m_read = {4'b0, m_stable};
      else if (adr_c == 5'd29) begin
        m_read = {4'b0, m_rise}; cr = m_rise;
      end else if (adr_c == 5'd30) begin
        m_read = {4'b0, m_fall}; cf = m_fall;
      end
    end
    m_rise = (m_rise & ~cr) | er;
    m_fall = (m_fall & ~cf) | ef;
    m_stable = nst;
    m_s2 = m_s1;
    m_s1 = in_c;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; gpio_in = '0; ReadIO = 1'b0; IOAdr = '0;
    model_reset();
    #2;
    checks++;
    if (IORead !== 32'h0 || IOValid !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs read=%h valid=%b irq=%b want 0/0/0",
               IORead, IOValid, irq);
    end
    ReadIO = 1'b1; IOAdr = 5'd28;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (IOValid !== 1'b0 || IORead !== 32'h0) begin
      failures++;
      $display("FAIL reset_strobe valid=%b read=%h want 0/0", IOValid, IORead);
    end
    reset = 1'b0; ReadIO = 1'b0;
    repeat (3) step();
    checks++;
    if (irq !== 1'b0 || IOValid !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle irq=%b valid=%b want 0/0", irq, IOValid);
    end
  endtask

  task automatic test_rise_pin5();
    logic [31:0] want;
    gpio_in[5] = 1'b1; ReadIO = 1'b1; IOAdr = 5'd5;
    for (int k = 1; k <= 12; k++) begin
      step();
      want = (k >= DEB + 3) ? 32'h1 : 32'h0;
      checks++;
      if (IORead !== want || IOValid !== 1'b1 || IORead !== m_read) begin
        failures++;
        $display("FAIL rise5 k=%0d read=%h valid=%b want %h/1 model %h",
                 k, IORead, IOValid, want, m_read);
      end
    end
    IOAdr = 5'd29;
    step();
    checks++;
    if (IORead !== 32'h20 || IORead !== m_read) begin
      failures++;
      $display("FAIL rise5_sts read=%h want 00000020", IORead);
    end
    ReadIO = 1'b0;
    step();
    checks++;
    if (IOValid !== 1'b0 || IORead !== 32'h0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL rise5_idle valid=%b read=%h irq=%b want 0/0/0",
               IOValid, IORead, irq);
    end
  endtask

  task automatic test_glitch_pin3();
    gpio_in[3] = 1'b1;
    repeat (5) step();
    gpio_in[3] = 1'b0;
    repeat (15) begin
      step();
      checks++;
      if (irq !== 1'b0) begin
        failures++;
        $display("FAIL glitch_irq irq=%b want 0", irq);
      end
    end
    ReadIO = 1'b1; IOAdr = 5'd28;
    step();
    checks++;
    if (IORead !== 32'h20 || IORead !== m_read) begin
      failures++;
      $display("FAIL glitch_level read=%h want 00000020", IORead);
    end
    IOAdr = 5'd29;
    step();
    checks++;
    if (IORead !== 32'h0) begin
      failures++;
      $display("FAIL glitch_rise read=%h want 0", IORead);
    end
    ReadIO = 1'b0;
    step();
  endtask

  task automatic test_multi_rise();
    gpio_in[0] = 1'b1; gpio_in[27] = 1'b1;
    repeat (DEB + 3) step();
    checks++;
    if (irq !== 1'b1 || irq !== m_irq()) begin
      failures++;
      $display("FAIL multi_irq irq=%b want 1", irq);
    end
    ReadIO = 1'b1; IOAdr = 5'd29;
    step();
    checks++;
    if (IORead !== 32'h0800_0001 || IORead !== m_read) begin
      failures++;
      $display("FAIL multi_read1 read=%h want 08000001", IORead);
    end
    checks++;
    if (irq !== 1'b0) begin
      failures++;
      $display("FAIL multi_irq_clr irq=%b want 0", irq);
    end
    step();
    checks++;
    if (IORead !== 32'h0 || IOValid !== 1'b1) begin
      failures++;
      $display("FAIL multi_read2 read=%h valid=%b want 0/1", IORead, IOValid);
    end
    ReadIO = 1'b0;
    step();
  endtask

  task automatic test_fall_collision();
    gpio_in[12] = 1'b1;
    repeat (DEB + 3) step();
    ReadIO = 1'b1; IOAdr = 5'd29;
    step();
    ReadIO = 1'b0;
    step();
    gpio_in[12] = 1'b0;
    repeat (DEB + 1) step();
    ReadIO = 1'b1; IOAdr = 5'd30;
    step();
    checks++;
    if (IORead !== 32'h0 || irq !== 1'b1) begin
      failures++;
      $display("FAIL fall_same read=%h irq=%b want 0/1", IORead, irq);
    end
    step();
    checks++;
    if (IORead !== 32'h0000_1000 || IORead !== m_read) begin
      failures++;
      $display("FAIL fall_next read=%h want 00001000", IORead);
    end
    ReadIO = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    logic [31:0] want;
    gpio_in[9] = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    #1;
    checks++;
    if (IORead !== 32'h0 || IOValid !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL midrst_out read=%h valid=%b irq=%b want 0/0/0",
               IORead, IOValid, irq);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (IOValid !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL midrst_hold valid=%b irq=%b want 0/0", IOValid, irq);
    end
    reset = 1'b0; ReadIO = 1'b1; IOAdr = 5'd28;
    for (int k = 1; k <= 12; k++) begin
      step();
      want = (k >= DEB + 3) ? 32'h0800_0221 : 32'h0;
      checks++;
      if (IORead !== want || IORead !== m_read) begin
        failures++;
        $display("FAIL midrst_level k=%0d read=%h want %h", k, IORead, want);
      end
    end
    IOAdr = 5'd29;
    step();
    checks++;
    if (IORead !== 32'h0800_0221) begin
      failures++;
      $display("FAIL midrst_rise read=%h want 08000221", IORead);
    end
    ReadIO = 1'b0;
    step();
  endtask

  task automatic test_rsvd_idle();
    ReadIO = 1'b1; IOAdr = 5'd31;
    step();
    checks++;
    if (IORead !== 32'h0 || IOValid !== 1'b1) begin
      failures++;
      $display("FAIL rsvd read=%h valid=%b want 0/1", IORead, IOValid);
    end
    ReadIO = 1'b0;
    repeat (5) begin
      step();
      checks++;
      if (IORead !== 32'h0 || IOValid !== 1'b0) begin
        failures++;
        $display("FAIL idle read=%h valid=%b want 0/0", IORead, IOValid);
      end
    end
    ReadIO = 1'b1; IOAdr = 5'd28;
    step();
    checks++;
    if (IORead !== {4'b0, gpio_in}) begin
      failures++;
      $display("FAIL level_word read=%h want %h", IORead, {4'b0, gpio_in});
    end
    ReadIO = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    ReadIO = 1'b1;
    for (int a = 0; a < 32; a++) begin
      IOAdr = 5'(a);
      step();
      checks++;
      if (IOValid !== 1'b1 || IORead !== m_read) begin
        failures++;
        $display("FAIL b2b adr=%0d read=%h valid=%b want %h/1",
                 a, IORead, IOValid, m_read);
      end
    end
    ReadIO = 1'b0;
    step();
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        gpio_in = gpio_in ^ 28'($urandom & $urandom & $urandom);
        hold = $urandom_range(1, 2 * DEB);
      end
      hold--;
      ReadIO = 1'($urandom % 2);
      IOAdr  = 5'($urandom % 32);
      step();
      checks++;
      if (IORead !== m_read || IOValid !== m_valid || irq !== m_irq()) begin
        failures++;
        $display("FAIL random c=%0d read=%h valid=%b irq=%b want %h/%b/%b",
                 c, IORead, IOValid, irq, m_read, m_valid, m_irq());
      end
    end
    ReadIO = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rise_pin5();
    test_glitch_pin3();
    test_multi_rise();
    test_fall_collision();
    test_reset_mid();
    test_rsvd_idle();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
